// File: rtl/mem_access_unit.sv
// Load/store unit between a requester and a word-wide data memory.
// Aligns, strobes and extends byte/half/word accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_r_addr,
  input  logic [31:0] mem_r_data,
  output logic [31:0] mem_w_addr,
  output logic [3:0]  mem_w_enable,
  output logic [31:0] mem_w_data
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, LOAD_WAIT, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        st_q, un_q, err_q;
  logic [1:0]  sz_q, off_q;
  logic [31:0] wd_q, idx_q, rd_q;

  logic        accept, err_in;
  logic [31:0] idx_in;
  logic [31:0] bsh, hsh, ld_val;
  logic [3:0]  strb;
  logic [31:0] wlane;

  assign idx_in = {2'b00, req_addr[31:2]};
  assign err_in = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && |req_addr[1:0])
               || (idx_in >= ADDR_WORDS);

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = err_in ? RESP : ACCESS;
      ACCESS:    state_d = st_q ? RESP : LOAD_WAIT;
      LOAD_WAIT: state_d = RESP;
      RESP:      if (resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Lane select and extension of the returned memory word
  assign bsh = mem_r_data >> {off_q, 3'b000};
  assign hsh = mem_r_data >> {off_q[1], 4'b0000};

  always_comb begin
    ld_val = mem_r_data;
    unique case (1'b1)
      sz_q == 2'b00:
        ld_val = {{24{~un_q & bsh[7]}}, bsh[7:0]};
      sz_q == 2'b01:
        ld_val = {{16{~un_q & hsh[15]}}, hsh[15:0]};
      default: ld_val = mem_r_data;
    endcase
  end

  always_comb begin
    strb  = 4'b0000;
    wlane = wd_q;
    unique case (1'b1)
      sz_q == 2'b00: begin
        strb  = 4'b0001 << off_q;
        wlane = {4{wd_q[7:0]}};
      end
      sz_q == 2'b01: begin
        strb  = 4'b0011 << {off_q[1], 1'b0};
        wlane = {2{wd_q[15:0]}};
      end
      sz_q == 2'b10: begin
        strb  = 4'b1111;
        wlane = wd_q;
      end
      default: begin
        strb  = 4'b0000;
        wlane = wd_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= 1'b0;
      un_q    <= 1'b0;
      err_q   <= 1'b0;
      sz_q    <= 2'b00;
      off_q   <= 2'b00;
      wd_q    <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        st_q  <= req_is_store;
        un_q  <= req_unsigned;
        err_q <= err_in;
        sz_q  <= req_size;
        off_q <= req_addr[1:0];
        wd_q  <= req_wdata;
        idx_q <= idx_in;
        rd_q  <= '0;
      end else if (state_q == LOAD_WAIT) begin
        rd_q <= ld_val;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rd_q;
  assign resp_err   = err_q;
  assign mem_r_addr = idx_q;
  assign mem_w_addr = idx_q;
  assign mem_w_data = wlane;

  // Reset gates the strobes so an in-flight store never lands
  assign mem_w_enable =
    (state_q == ACCESS && st_q && !rst) ? strb : 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic
// against a byte-level memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;
  logic [3:0]  mem_w_enable;

  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_r_addr   (mem_r_addr),
    .mem_r_data   (mem_r_data),
    .mem_w_addr   (mem_w_addr),
    .mem_w_enable (mem_w_enable),
    .mem_w_data   (mem_w_data)
  );

  // Attached synchronous RAM (only the low 256 words are exercised)
  always @(posedge clk) begin
    if (pl_en)
      ram[pl_idx] <= pl_dat;
    for (int b = 0; b < 4; b++)
      if (mem_w_enable[b])
        ram[mem_w_addr[7:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
    mem_r_data <= ram[mem_r_addr[7:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(
    input logic [31:0] a, input int n, input logic un);
    logic [31:0] w, v;
    int off;
    w   = ref_mem[a[9:2]];
    off = int'(a[1:0]);
    v   = '0;
    for (int k = 0; k < n; k++)
      v = v | (((w >> (8*(off+k))) & 32'hFF) << (8*k));
    if (!un && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n,
                           input logic [31:0] wd);
    int off;
    off = int'(a[1:0]);
    for (int k = 0; k < n; k++)
      ref_mem[a[9:2]][8*(off+k) +: 8] = wd[8*k +: 8];
  endtask

  task automatic xact(input logic st, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] wd, input int stall,
                      output logic [31:0] o_rd,
                      output logic [3:0] o_we,
                      output logic [31:0] o_wd);
    int n, lat, nwr, e_lat;
    logic e_err;
    logic [31:0] idx, e_rd, e_wd, held;
    logic [3:0] e_we;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    idx   = a >> 2;
    e_err = (sz == 2'd3) || (a % n != 0) || (idx >= 32768);
    e_lat = e_err ? 1 : (st ? 2 : 3);
    e_rd  = (e_err || st) ? 32'h0 : ref_load(a, n, un);
    e_we  = (st && !e_err) ? 4'(((1 << n) - 1) << a[1:0]) : 4'h0;
    for (int j = 0; j < 4; j++)
      e_wd[8*j +: 8] = wd[8*(j % n) +: 8];
    o_rd = '0; o_we = '0; o_wd = '0;

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    resp_ready   = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    nwr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_w_enable != 4'h0) begin
        nwr++;
        o_we = mem_w_enable;
        o_wd = mem_w_data;
        chk("w_en", 32'(mem_w_enable), 32'(e_we));
        chk("w_addr", mem_w_addr, idx);
        chk("w_data", mem_w_data & {{8{e_we[3]}}, {8{e_we[2]}},
            {8{e_we[1]}}, {8{e_we[0]}}}, e_wd & {{8{e_we[3]}},
            {8{e_we[2]}}, {8{e_we[1]}}, {8{e_we[0]}}});
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("n_writes", 32'(nwr), (st && !e_err) ? 32'd1 : 32'd0);
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rd);
    o_rd = resp_rdata;
    held = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      req_is_store = 1'b1;
      req_size  = 2'b10;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_idx", mem_w_addr, idx);
      chk("hold_we", 32'(mem_w_enable), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("valid_drop", 32'(resp_valid), 32'd0);
    if (st && !e_err)
      ref_store(a, n, wd);
  endtask

  logic [31:0] rd, wdo;
  logic [3:0]  we;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 8'(i);
      pl_dat = (i == 8'h41) ? 32'h8000FF7F : $urandom;
      ref_mem[i] = pl_dat;
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_raddr", mem_r_addr, 32'd0);
    chk("rst_waddr", mem_w_addr, 32'd0);
    chk("rst_wdata", mem_w_data, 32'd0);
    chk("rst_we", 32'(mem_w_enable), 32'd0);
    rst = 1'b0;

    // Loads from a known word, then a byte store into it
    xact(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 0, rd, we, wdo);
    chk("ldh_s", rd, 32'hFFFF8000);
    xact(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 0, rd, we, wdo);
    chk("ldh_u", rd, 32'h00008000);
    xact(1'b0, 2'b00, 1'b0, 32'h105, 32'h0, 0, rd, we, wdo);
    chk("ldb_s", rd, 32'hFFFFFFFF);
    xact(1'b1, 2'b00, 1'b0, 32'h105, 32'hAB, 0, rd, we, wdo);
    chk("stb_we", 32'(we), 32'h2);
    chk("stb_wd", wdo, 32'hABABABAB);

    // Error paths: misaligned, illegal size, out of range
    xact(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, rd, we, wdo);
    xact(1'b1, 2'b01, 1'b0, 32'h003, 32'h1234, 0, rd, we, wdo);
    xact(1'b1, 2'b11, 1'b0, 32'h008, 32'h55, 0, rd, we, wdo);
    xact(1'b1, 2'b10, 1'b0, 32'h00020000, 32'h77, 0,
         rd, we, wdo);

    // Long response backpressure
    xact(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5, rd, we, wdo);

    // Reset during the write cycle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b10;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_gate_we", 32'(mem_w_enable), 32'd0);
    chk("rst_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", 32'(resp_err), 32'd0);
    chk("post_waddr", mem_w_addr, 32'd0);
    chk("post_wdata", mem_w_data, 32'd0);
    chk("post_we", 32'(mem_w_enable), 32'd0);
    chk("word4_kept", ram[4], ref_mem[4]);

    // Random traffic
    for (int t = 0; t < 120; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0)
          ? 32'h00020000 + $urandom_range(0, 255)
          : 32'($urandom_range(0, 1023));
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 3), rd, we, wdo);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++)
      chk("ram_final", ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 32768, meaning the number of 32-bit words in the attached data memory; legal word indices are 0..ADDR_WORDS-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the requester offers a load or store.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port req_is_store, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port resp_ready, input, 1 bit: the requester accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: the request was misaligned, illegal or out of range.
REQ-015 SHALL have port mem_r_addr, output, 32 bits: memory read word index.
REQ-016 SHALL have port mem_r_data, input, 32 bits: memory read data, valid one cycle after mem_r_addr is sampled.
REQ-017 SHALL have port mem_w_addr, output, 32 bits: memory write word index.
REQ-018 SHALL have port mem_w_enable, output, 4 bits: per-byte write strobes.
REQ-019 SHALL have port mem_w_data, output, 32 bits: lane-positioned write data.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, LOAD_WAIT, RESP.
- req_ready = 1 only in IDLE.
- A request is accepted at a rising edge with req_valid && req_ready.
REQ-021 SHALL on acceptance register all req_* fields, the word index {2'b00, req_addr[31:2]} and the error flag.
- Error flag set when: size 11, half with addr[0]=1, word with addr[1:0]!=00, or word index >= ADDR_WORDS.
REQ-022 SHALL route an errored request IDLE->RESP with resp_err=1 and resp_rdata=0; no write strobe is ever issued for it.
REQ-023 SHALL route a legal request IDLE->ACCESS.
- From ACCESS: stores go to RESP, loads go to LOAD_WAIT.
- From LOAD_WAIT: always go to RESP.
REQ-024 SHALL drive mem_r_addr and mem_w_addr from the registered word index at all times after the first acceptance (0 after reset).
REQ-025 SHALL assert mem_w_enable only in ACCESS for a store, with these strobes and data:
- byte: 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}
- half: 4'b0011<<{addr[1],1'b0}, data = {2{wdata[15:0]}}
- word: 4'b1111, data = wdata
- mem_w_enable SHALL be 0 in every other cycle.
REQ-026 SHALL in LOAD_WAIT capture mem_r_data, select the lane by addr[1:0] (byte) or addr[1] (half), extend per req_unsigned, and present the result on resp_rdata in RESP.
REQ-027 SHALL in RESP hold resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1, then go to IDLE on that edge; resp_valid=0 in all other states.
REQ-028 SHALL give the following latency from the acceptance edge to resp_valid: error 1 cycle, store 2 cycles, load 3 cycles (at resp_ready=1, throughput is one request per 2/3/4 cycles).
REQ-029 SHALL not change the registered request while busy; req_valid outside IDLE is ignored.

Reset
REQ-030 SHALL when rst=1 at a rising edge force state IDLE and clear resp_valid, resp_err, resp_rdata, mem_r_addr, mem_w_addr, mem_w_data and the registered request.
REQ-031 SHALL gate mem_w_enable to 0 combinationally while rst=1, so a store in ACCESS coincident with reset never writes.
REQ-032 SHALL not accept a request in the reset cycle (req_ready=0 while rst=1); a pending response is discarded.

Verification
REQ-033 Store byte addr 0x00000105, wdata 0xAB -> one ACCESS cycle with mem_w_addr=0x41, mem_w_enable=0010, mem_w_data=0xABABABAB; resp_valid 2 cycles after accept, resp_err=0.
REQ-034 Memory word 0x41 = 0x8000FF7F; load half signed addr 0x106 -> resp_rdata=0xFFFF8000 at 3 cycles; same load unsigned -> 0x00008000; load byte signed addr 0x105 -> 0xFFFFFFFF.
REQ-035 Load word addr 0x102, then store half addr 0x3, then size 11 -> each resp_err=1 after 1 cycle, mem_w_enable stays 0000 throughout.
REQ-036 Word addr 0x00020000 with ADDR_WORDS=32768 -> resp_err=1, no write.
REQ-037 Load completes with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held constant; req_ready=0; second req_valid ignored; IDLE after resp_ready pulse.
REQ-038 Assert rst in the ACCESS cycle of a word store to 0x10 -> mem_w_enable=0000, memory word 4 unchanged, next cycle IDLE with all outputs 0.
